// File: rtl/slot_pkg.sv
// slot_pkg: shared constants and types for the slot reel controller.
//   SYMBOL_W       - width of one reel symbol index
//   SLOWDOWN_STEPS - ticks a reel keeps moving after a stop when
//                    SLOT_SLOWDOWN_EN is defined
//   state_e        - controller FSM states
//   symbol_step    - next symbol on a tick (3-bit wraparound)
package slot_pkg;

  localparam int SYMBOL_W       = 3;
  localparam int SLOWDOWN_STEPS = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SPIN   = 2'd1,
    EVAL   = 2'd2,
    RESULT = 2'd3
  } state_e;

  // Symbols wrap 7 -> 0 by plain width truncation.
  function automatic logic [SYMBOL_W-1:0] symbol_step(input logic [SYMBOL_W-1:0] sym);
    return sym + SYMBOL_W'(1);
  endfunction

endpackage

// File: rtl/slot_reel.sv
// slot_reel: one reel. Owns the symbol counter, the spinning flag and,
// when SLOT_SLOWDOWN_EN is defined, the slowdown counter.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   tick        - step strobe from the controller prescaler (SPIN only)
//   spin_start  - one-cycle pulse: start moving (symbol is kept)
//   stop_edge   - qualified stop request (controller is in SPIN)
//   symbol      - current symbol index
//   spinning    - 1 while the reel is moving
// Build option: SLOT_SLOWDOWN_EN - a stop lets the reel run
// SLOWDOWN_STEPS more ticks before it halts.
module slot_reel
  import slot_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                spin_start,
  input  logic                stop_edge,
  output logic [SYMBOL_W-1:0] symbol,
  output logic                spinning
);

  logic [SYMBOL_W-1:0] symbol_q;
  logic                spinning_q;

  assign symbol   = symbol_q;
  assign spinning = spinning_q;

`ifdef SLOT_SLOWDOWN_EN
  localparam int SLOW_W = $clog2(SLOWDOWN_STEPS + 1);
  localparam logic [SLOW_W-1:0] SLOW_LAST = SLOW_W'(SLOWDOWN_STEPS - 1);

  logic              slow_q;
  logic [SLOW_W-1:0] slow_cnt_q;

  // Symbol stepping, spinning flag and slowdown countdown.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      symbol_q   <= '0;
      spinning_q <= 1'b0;
      slow_q     <= 1'b0;
      slow_cnt_q <= '0;
    end else begin
      if (spinning_q && tick) begin
        symbol_q <= symbol_step(symbol_q);
      end
      if (spin_start) begin
        spinning_q <= 1'b1;
        slow_q     <= 1'b0;
        slow_cnt_q <= '0;
      end else if (slow_q) begin
        // Later stop edges are ignored; only ticks move the countdown.
        if (tick) begin
          if (slow_cnt_q == SLOW_LAST) begin
            spinning_q <= 1'b0;
            slow_q     <= 1'b0;
            slow_cnt_q <= '0;
          end else begin
            slow_cnt_q <= slow_cnt_q + SLOW_W'(1);
          end
        end
      end else if (stop_edge && spinning_q) begin
        // A tick on this same edge still steps but is not counted.
        slow_q     <= 1'b1;
        slow_cnt_q <= '0;
      end
    end
  end
`else
  // Symbol stepping and immediate stop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      symbol_q   <= '0;
      spinning_q <= 1'b0;
    end else begin
      // A stop on a tick edge still takes that tick's increment.
      if (spinning_q && tick) begin
        symbol_q <= symbol_step(symbol_q);
      end
      if (spin_start) begin
        spinning_q <= 1'b1;
      end else if (stop_edge && spinning_q) begin
        spinning_q <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: rtl/slot_reel_controller.sv
// slot_reel_controller: sequences REELS slot reels between debounced
// buttons and the per-reel 7-segment pattern decoders.
// Ports:
//   clk, reset    - clock, asynchronous active-high reset
//   startButton   - start request level (rising edge acts)
//   stopButton    - per-reel stop request levels (rising edges act)
//   reelSymbol    - symbol of reel i at [3i+2:3i]
//   reelSpinning  - 1 while reel i moves
//   busy          - 1 in SPIN and EVAL
//   win           - all symbols equal in the last game; valid in RESULT
// Build option: SLOT_SLOWDOWN_EN (see slot_reel).
module slot_reel_controller
  import slot_pkg::*;
#(
  parameter int REELS    = 3,
  parameter int STEP_DIV = 2500000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      startButton,
  input  logic [REELS-1:0]          stopButton,
  output logic [SYMBOL_W*REELS-1:0] reelSymbol,
  output logic [REELS-1:0]          reelSpinning,
  output logic                      busy,
  output logic                      win
);

  localparam int CNT_W = $clog2(STEP_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_DIV - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               start_prev_q;
  logic [REELS-1:0]   stop_prev_q;
  logic               busy_q, busy_d;
  logic               win_q, win_d;

  logic               start_edge_s;
  logic [REELS-1:0]   stop_edge_s;
  logic [REELS-1:0]   reel_stop_s;
  logic               tick_s;
  logic               spin_start_s;
  logic               all_stopped_s;
  logic               all_equal_s;

  // Button history; resets to 1 so a button held through reset is not an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_prev_q <= 1'b1;
      stop_prev_q  <= '1;
    end else begin
      start_prev_q <= startButton;
      stop_prev_q  <= stopButton;
    end
  end

  assign start_edge_s  = startButton & ~start_prev_q;
  assign stop_edge_s   = stopButton & ~stop_prev_q;
  assign reel_stop_s   = stop_edge_s & {REELS{state_q == SPIN}};
  assign tick_s        = (state_q == SPIN) && (cnt_q == CNT_MAX);
  assign all_stopped_s = ~|reelSpinning;

  // Step prescaler: restarts on SPIN entry, runs only while in SPIN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (spin_start_s) begin
      cnt_q <= '0;
    end else if (state_q == SPIN) begin
      cnt_q <= tick_s ? '0 : cnt_q + CNT_W'(1);
    end else begin
      cnt_q <= '0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start_edge_s ? SPIN : IDLE;
      SPIN:    state_d = all_stopped_s ? EVAL : SPIN;
      EVAL:    state_d = RESULT;
      RESULT:  state_d = start_edge_s ? SPIN : RESULT;
      default: state_d = IDLE;
    endcase
  end

  // Win compare: every reel against reel 0.
  always_comb begin
    all_equal_s = 1'b1;
    for (int i = 1; i < REELS; i++) begin
      all_equal_s = all_equal_s &
                    (reelSymbol[i*SYMBOL_W +: SYMBOL_W] == reelSymbol[SYMBOL_W-1:0]);
    end
  end

  // FSM outputs: spin start pulse and next values of busy/win.
  always_comb begin
    spin_start_s = 1'b0;
    case (state_q)
      IDLE:    spin_start_s = start_edge_s;
      RESULT:  spin_start_s = start_edge_s;
      default: spin_start_s = 1'b0;
    endcase
    busy_d = (state_d == SPIN) || (state_d == EVAL);
    if (spin_start_s) begin
      win_d = 1'b0;
    end else if (state_q == EVAL) begin
      win_d = all_equal_s;
    end else begin
      win_d = win_q;
    end
  end

  // Registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      win_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      win_q  <= win_d;
    end
  end

  assign busy = busy_q;
  assign win  = win_q;

  for (genvar g = 0; g < REELS; g++) begin : g_reel
    slot_reel u_reel (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick_s),
      .spin_start (spin_start_s),
      .stop_edge  (reel_stop_s[g]),
      .symbol     (reelSymbol[g*SYMBOL_W +: SYMBOL_W]),
      .spinning   (reelSpinning[g])
    );
  end

endmodule

// File: tb/tb_slot_reel_controller.sv
// tb_slot_reel_controller: scoreboard bench for slot_reel_controller with
// REELS = 3, STEP_DIV = 4. Expected final symbols/win are pushed when a
// game's stops are scheduled and popped when the DUT reaches RESULT.
// Honours SLOT_SLOWDOWN_EN (reels then land two ticks later).
module tb_slot_reel_controller;

  localparam int REELS    = 3;
  localparam int STEP_DIV = 4;
`ifdef SLOT_SLOWDOWN_EN
  localparam int SLOW_EXTRA = 2;
`else
  localparam int SLOW_EXTRA = 0;
`endif

  logic             clk;
  logic             reset;
  logic             startButton;
  logic [REELS-1:0] stopButton;
  logic [3*REELS-1:0] reelSymbol;
  logic [REELS-1:0] reelSpinning;
  logic             busy;
  logic             win;

  typedef struct {
    logic [8:0] sym;
    logic       win;
  } exp_t;

  exp_t sb_q[$];
  int   exp_sym[3];
  int   checks_cnt;
  int   errors_cnt;

  slot_reel_controller #(.REELS(REELS), .STEP_DIV(STEP_DIV)) dut (
    .clk          (clk),
    .reset        (reset),
    .startButton  (startButton),
    .stopButton   (stopButton),
    .reelSymbol   (reelSymbol),
    .reelSpinning (reelSpinning),
    .busy         (busy),
    .win          (win)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [8:0] pack_exp();
    logic [2:0] s0, s1, s2;
    s0 = 3'(exp_sym[0]);
    s1 = 3'(exp_sym[1]);
    s2 = 3'(exp_sym[2]);
    return {s2, s1, s0};
  endfunction

  task automatic do_reset();
    reset       = 1'b1;
    startButton = 1'b0;
    stopButton  = 3'b000;
    step(2);
    chk("rst_sym", 32'(reelSymbol), 32'd0);
    chk("rst_spin", 32'(reelSpinning), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_win", 32'(win), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) exp_sym[i] = 0;
    sb_q.delete();
    step(1);
  endtask

  // One game: start, stop reel i on the edge ki cycles after the start edge.
  task automatic game(input int k0, input int k1, input int k2);
    int         ks[3];
    int         kmax;
    int         n;
    logic [8:0] prev_sym;
    logic [2:0] mask;
    exp_t       e;
    exp_t       got;
    ks       = '{k0, k1, k2};
    kmax     = k0;
    if (k1 > kmax) kmax = k1;
    if (k2 > kmax) kmax = k2;
    prev_sym = pack_exp();
    for (int i = 0; i < 3; i++) exp_sym[i] = (exp_sym[i] + ks[i] / STEP_DIV + SLOW_EXTRA) % 8;
    e.sym = pack_exp();
    e.win = (exp_sym[0] == exp_sym[1]) && (exp_sym[1] == exp_sym[2]);
    sb_q.push_back(e);

    startButton = 1'b1;
    step(1);
    startButton = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_spin", 32'(reelSpinning), 32'd7);
    chk("start_win", 32'(win), 32'd0);
    chk("start_sym", 32'(reelSymbol), 32'(prev_sym));

    for (int c = 1; c <= kmax; c++) begin
      mask = 3'b000;
      for (int i = 0; i < 3; i++) if (ks[i] == c) mask[i] = 1'b1;
      stopButton  = mask;
      startButton = (c == 2);   // a start edge during SPIN must be ignored
      step(1);
      stopButton  = 3'b000;
      startButton = 1'b0;
      for (int i = 0; i < 3; i++)
        if (ks[i] == c) chk("stop_spin", 32'(reelSpinning[i]), 32'(SLOW_EXTRA != 0));
    end

    n = 0;
    while (reelSpinning != 3'b000 && n < 200) begin
      step(1);
      n++;
    end
    if (n >= 200) chk("spin_timeout", 32'(reelSpinning), 32'd0);
    chk("spin_busy", 32'(busy), 32'd1);
    step(1);
    chk("eval_busy", 32'(busy), 32'd1);
    step(1);
    chk("result_busy", 32'(busy), 32'd0);

    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      got = sb_q.pop_front();
      chk("result_sym", 32'(reelSymbol), 32'(got.sym));
      chk("result_win", 32'(win), 32'(got.win));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    checks_cnt  = 0;
    errors_cnt  = 0;
    reset       = 1'b1;
    startButton = 1'b0;
    stopButton  = 3'b000;

    // 1: stops in IDLE do nothing
    do_reset();
    stopButton = 3'b111;
    step(1);
    stopButton = 3'b000;
    step(3);
    chk("idle_sym", 32'(reelSymbol), 32'd0);
    chk("idle_spin", 32'(reelSpinning), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // 2: three ticks, simultaneous stop; stops in RESULT ignored
    game(13, 13, 13);
    stopButton = 3'b111;
    step(1);
    stopButton = 3'b000;
    step(2);
    chk("res_hold_sym", 32'(reelSymbol), 32'(pack_exp()));
    chk("res_hold_win", 32'(win), 32'((exp_sym[0] == exp_sym[1]) && (exp_sym[1] == exp_sym[2])));
    chk("res_hold_busy", 32'(busy), 32'd0);

    // 3: nine ticks from zero, wraps through 7
    do_reset();
    game(37, 37, 37);

    // 4: staggered stops, then a resumed game
    do_reset();
    game(10, 22, 22);
    game(17, 6, 6);

    // 5: async reset mid-SPIN with start held
    startButton = 1'b1;
    step(1);
    step(6);
    #3;
    reset = 1'b1;
    #1;
    chk("async_sym", 32'(reelSymbol), 32'd0);
    chk("async_spin", 32'(reelSpinning), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) exp_sym[i] = 0;
    sb_q.delete();
    step(10);
    chk("held_busy", 32'(busy), 32'd0);
    chk("held_spin", 32'(reelSpinning), 32'd0);
    chk("held_sym", 32'(reelSymbol), 32'd0);
    startButton = 1'b0;
    step(1);
    game(5, 6, 7);

    // 6: stop between ticks and stop coincident with a tick
    do_reset();
    game(9, 8, 20);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
